// File: rtl/player_bullet_ctrl_if.sv
// Collision link between the player bullet and the alien group: the bullet's
// bounding box goes out, the alien group's hit indication comes back.
interface player_bullet_ctrl_if;
  logic               alien_hit;
  logic               bullet_active;
  logic signed [11:0] bullet_left;
  logic signed [11:0] bullet_right;
  logic signed [11:0] bullet_top;
  logic signed [11:0] bullet_bottom;

  modport master (
    input  alien_hit,
    output bullet_active, bullet_left, bullet_right, bullet_top, bullet_bottom
  );

  modport slave (
    output alien_hit,
    input  bullet_active, bullet_left, bullet_right, bullet_top, bullet_bottom
  );
endinterface

// File: rtl/player_bullet_ctrl.sv
// Player shot generator: launches one bullet from the ship on a fire press,
// moves it up once per frame, retires it on a hit or at the screen top, then cools down.
module player_bullet_ctrl #(
  parameter int BULLET_W        = 2,
  parameter int BULLET_H        = 8,
  parameter int BULLET_SPEED    = 6,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int SHIP_W          = 32
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 fsync,
  input  logic signed [11:0]   hpos,
  input  logic signed [11:0]   vpos,
  input  logic                 fire_btn,
  input  logic signed [11:0]   ship_x,
  input  logic signed [11:0]   ship_top,
  player_bullet_ctrl_if.master coll,
  output logic [7:0]           pixel [0:2],
  output logic                 active,
  output logic [7:0]           shots_fired,
  output logic [7:0]           hits_scored
);

  localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

  state_t             state, state_d;
  logic               btn_s1, btn_s2, btn_s3;
  logic               btn_rise;
  logic               fire_pending;
  logic [CNT_W-1:0]   cd_cnt;
  logic signed [11:0] left_q, right_q, top_q, bottom_q;
  logic signed [11:0] spawn_left, spawn_top_v, moved_top;
  logic [7:0]         shots_q, hits_q;
  logic               launch, hit, retire, move, cd_tick;
  logic               in_box;

  // Spawn height is clamped so a ship hugging the top never spawns off-screen.
  function automatic logic signed [11:0] clamp_spawn_top(input logic signed [11:0] top_v);
    logic signed [12:0] t;
    t = {top_v[11], top_v} - 13'(BULLET_H);
    return (t < 13'sd0) ? 12'sd0 : t[11:0];
  endfunction

  // Done in 13 bits so a small top value cannot wrap to a large positive one.
  function automatic logic top_exits(input logic signed [11:0] top_v);
    logic signed [12:0] t;
    t = {top_v[11], top_v} - 13'(BULLET_SPEED);
    return t < 13'sd0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign btn_rise    = btn_s2 & ~btn_s3;
  assign spawn_left  = ship_x + 12'(SHIP_W / 2 - BULLET_W / 2);
  assign spawn_top_v = clamp_spawn_top(ship_top);
  assign moved_top   = top_q - 12'(BULLET_SPEED);

  always_ff @(posedge pixel_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    hit     = 1'b0;
    retire  = 1'b0;
    move    = 1'b0;
    cd_tick = 1'b0;
    unique case (state)
      IDLE: begin
        if (fsync && fire_pending) begin
          launch  = 1'b1;
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        // A hit wins over a same-cycle frame tick, so the box freezes where it was hit.
        if (coll.alien_hit) begin
          hit     = 1'b1;
          state_d = COOLDOWN;
        end else if (fsync) begin
          if (top_exits(top_q)) begin
            retire  = 1'b1;
            state_d = COOLDOWN;
          end else begin
            move = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (fsync) begin
          cd_tick = 1'b1;
          if (cd_cnt == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_s3       <= 1'b0;
      fire_pending <= 1'b0;
      cd_cnt       <= '0;
      shots_q      <= 8'd0;
      hits_q       <= 8'd0;
      left_q       <= 12'sd0;
      right_q      <= 12'sd0;
      top_q        <= 12'sd0;
      bottom_q     <= 12'sd0;
    end else begin
      btn_s1 <= fire_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      // Presses outside IDLE are discarded rather than queued.
      if (launch)                         fire_pending <= 1'b0;
      else if (state == IDLE && btn_rise) fire_pending <= 1'b1;
      if (hit || retire) cd_cnt <= CNT_W'(COOLDOWN_FRAMES);
      else if (cd_tick)  cd_cnt <= cd_cnt - 1'b1;
      if (launch) begin
        left_q   <= spawn_left;
        right_q  <= spawn_left + 12'(BULLET_W);
        top_q    <= spawn_top_v;
        bottom_q <= spawn_top_v + 12'(BULLET_H);
        shots_q  <= shots_q + 8'd1;
      end else if (move) begin
        top_q    <= moved_top;
        bottom_q <= moved_top + 12'(BULLET_H);
      end
      if (hit) hits_q <= sat_inc(hits_q);
    end
  end

  assign coll.bullet_active = (state == FLIGHT);
  assign coll.bullet_left   = left_q;
  assign coll.bullet_right  = right_q;
  assign coll.bullet_top    = top_q;
  assign coll.bullet_bottom = bottom_q;
  assign shots_fired        = shots_q;
  assign hits_scored        = hits_q;

  assign in_box = (hpos >= left_q) && (hpos < right_q) &&
                  (vpos >= top_q)  && (vpos < bottom_q);
  assign active   = (state == FLIGHT) && in_box;
  assign pixel[0] = 8'h00;
  assign pixel[1] = active ? 8'hFF : 8'h00;
  assign pixel[2] = active ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Scoreboard bench for player_bullet_ctrl: directed scenarios followed by random
// frames, each cycle checked against a frame-level reference model.
module tb_player_bullet_ctrl;
  localparam int BW = 2, BH = 8, SPD = 6, CD = 4, SW = 32;

  logic               pixel_clk = 1'b0;
  logic               rst, fsync, fire_btn;
  logic signed [11:0] hpos, vpos, ship_x, ship_top;
  logic [7:0]         pixel [0:2];
  logic               active;
  logic [7:0]         shots_fired, hits_scored;

  player_bullet_ctrl_if bus ();

  player_bullet_ctrl #(.BULLET_W(BW), .BULLET_H(BH), .BULLET_SPEED(SPD),
                       .COOLDOWN_FRAMES(CD), .SHIP_W(SW)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .fire_btn(fire_btn), .ship_x(ship_x), .ship_top(ship_top), .coll(bus),
    .pixel(pixel), .active(active), .shots_fired(shots_fired), .hits_scored(hits_scored)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    bit fly;
    int l, r, t, b;
    int shots, hits;
    bit ract;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bullet in flight or not, frames of cooldown left, and a
  // history of raw button samples (newest first).
  bit m_fly, m_pend;
  int m_cd, m_l, m_r, m_t, m_b, m_shots, m_hits;
  bit btn_hist[$];
  int hp_g, vp_g;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit r, input bit f, input bit b, input bit h,
                                     input int sx, input int st);
    bit rise, idle, launched;
    if (r) begin
      m_fly = 0; m_pend = 0; m_cd = 0;
      m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_shots = 0; m_hits = 0;
      btn_hist = '{0, 0, 0};
      return;
    end
    // A press reaches the pending flag three edges after it is sampled.
    rise     = btn_hist[1] && !btn_hist[2];
    idle     = !m_fly && (m_cd == 0);
    launched = 0;
    if (m_fly && h) begin
      m_fly = 0; m_cd = CD;
      m_hits = (m_hits < 255) ? m_hits + 1 : 255;
    end else if (m_fly && f) begin
      if (m_t - SPD < 0) begin
        m_fly = 0; m_cd = CD;
      end else begin
        m_t = m_t - SPD; m_b = m_t + BH;
      end
    end else if (!m_fly && m_cd > 0) begin
      if (f) m_cd--;
    end else if (idle && f && m_pend) begin
      launched = 1;
      m_l = sx + SW / 2 - BW / 2; m_r = m_l + BW;
      m_t = (st - BH < 0) ? 0 : st - BH; m_b = m_t + BH;
      m_shots = (m_shots + 1) % 256;
      m_fly = 1;
    end
    if (launched)          m_pend = 0;
    else if (idle && rise) m_pend = 1;
    btn_hist.push_front(b);
    void'(btn_hist.pop_back());
  endfunction

  task automatic step(input bit r, input bit f, input bit b, input bit h);
    exp_t e;
    rst = r; fsync = f; fire_btn = b; bus.alien_hit = h;
    hpos = 12'(hp_g); vpos = 12'(vp_g);
    @(posedge pixel_clk);
    model_edge(r, f, b, h, int'(ship_x), int'(ship_top));
    e.fly = m_fly; e.l = m_l; e.r = m_r; e.t = m_t; e.b = m_b;
    e.shots = m_shots; e.hits = m_hits;
    e.ract = m_fly && hp_g >= m_l && hp_g < m_r && vp_g >= m_t && vp_g < m_b;
    sb_q.push_back(e);
    #3;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0);
      idle_cycles(5);
    end
  endtask

  task automatic press();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    idle_cycles(4);
  endtask

  always @(posedge pixel_clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("bullet_active", int'(bus.bullet_active), int'(e.fly));
      cmp("bullet_left",   int'(bus.bullet_left),   e.l);
      cmp("bullet_right",  int'(bus.bullet_right),  e.r);
      cmp("bullet_top",    int'(bus.bullet_top),    e.t);
      cmp("bullet_bottom", int'(bus.bullet_bottom), e.b);
      cmp("shots_fired",   int'(shots_fired),       e.shots);
      cmp("hits_scored",   int'(hits_scored),       e.hits);
      cmp("active",        int'(active),            int'(e.ract));
      cmp("pixel_b",       int'(pixel[0]),          0);
      cmp("pixel_g",       int'(pixel[1]),          e.ract ? 255 : 0);
      cmp("pixel_r",       int'(pixel[2]),          e.ract ? 255 : 0);
    end
  end

  initial begin
    btn_hist = '{0, 0, 0};
    hp_g = 0; vp_g = 0;
    ship_x = 12'sd300; ship_top = 12'sd440;
    bus.alien_hit = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    cmp("rst_shots", int'(shots_fired), 0);
    cmp("rst_active", int'(bus.bullet_active), 0);
    idle_cycles(2);

    // Launch from ship_x=300, ship_top=440.
    press();
    step(0, 1, 0, 0);
    cmp("launch_active", int'(bus.bullet_active), 1);
    cmp("launch_left",   int'(bus.bullet_left), 315);
    cmp("launch_right",  int'(bus.bullet_right), 317);
    cmp("launch_top",    int'(bus.bullet_top), 432);
    cmp("launch_bottom", int'(bus.bullet_bottom), 440);
    cmp("launch_shots",  int'(shots_fired), 1);

    // Render corners of the box.
    hp_g = 315; vp_g = 432; step(0, 0, 0, 0);
    cmp("render_in", int'(active), 1);
    cmp("render_in_g", int'(pixel[1]), 255);
    hp_g = 317; vp_g = 432; step(0, 0, 0, 0);
    cmp("render_right_edge", int'(active), 0);
    hp_g = 315; vp_g = 440; step(0, 0, 0, 0);
    cmp("render_bottom_edge", int'(pixel[2]), 0);
    hp_g = 0; vp_g = 0;
    idle_cycles(3);

    frames(1);
    cmp("move_top", int'(bus.bullet_top), 426);

    // Hit coincident with fsync, then held for five cycles.
    step(0, 1, 0, 1);
    cmp("hit_active", int'(bus.bullet_active), 0);
    cmp("hit_top", int'(bus.bullet_top), 426);
    cmp("hit_count", int'(hits_scored), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    cmp("hit_held_count", int'(hits_scored), 1);

    // Press during cooldown is dropped.
    press();
    frames(4);
    frames(1);
    cmp("cooldown_press_dropped", int'(shots_fired), 1);

    // Relaunch and ride to the top edge.
    press();
    step(0, 1, 0, 0);
    idle_cycles(3);
    cmp("relaunch_shots", int'(shots_fired), 2);
    press();
    frames(72);
    cmp("edge_top_zero", int'(bus.bullet_top), 0);
    cmp("flight_press_dropped", int'(shots_fired), 2);
    frames(1);
    cmp("edge_retired", int'(bus.bullet_active), 0);
    cmp("edge_hits", int'(hits_scored), 1);
    frames(4);
    press();
    step(0, 1, 0, 0);
    cmp("edge_relaunch", int'(bus.bullet_active), 1);

    // Reset mid-flight, then an fsync must not launch.
    step(1, 0, 0, 0);
    cmp("midrst_active", int'(bus.bullet_active), 0);
    cmp("midrst_left", int'(bus.bullet_left), 0);
    cmp("midrst_shots", int'(shots_fired), 0);
    step(0, 1, 0, 0);
    cmp("midrst_no_launch", int'(bus.bullet_active), 0);

    // Random frames.
    begin
      bit btn = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) btn = ~btn;
        if ($urandom_range(0, 99) == 0) begin
          ship_x   = 12'($urandom_range(0, 600));
          ship_top = 12'($urandom_range(0, 3) == 0 ? $urandom_range(0, 12) : $urandom_range(0, 470));
        end
        hp_g = m_l + int'($urandom_range(0, 4)) - 1;
        vp_g = m_t + int'($urandom_range(0, 10)) - 1;
        step($urandom_range(0, 799) == 0, $urandom_range(0, 5) == 0, btn,
             $urandom_range(0, 59) == 0);
      end
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge pixel_clk);
    #2;
    cmp("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_bullet_ctrl.md
# player_bullet_ctrl

Player-side shot generator feeding the alien group's collision inputs. It turns the fire button into a single upward-moving bullet launched from the ship, advances the bullet once per frame and publishes its bounding box to the alien group's collision logic. It retires the bullet on an alien hit or on leaving the top of the screen, then enforces a frame-count cooldown. It also renders the bullet into the pixel mux.

## Interface
Parameters:
- BULLET_W, 2, bullet width in pixels
- BULLET_H, 8, bullet height in pixels
- BULLET_SPEED, 6, pixels moved up per frame (≥1)
- COOLDOWN_FRAMES, 4, frames between retire and next allowed launch (≥1)
- SHIP_W, 32, ship width used to centre the spawn

Ports:
- pixel_clk  in  1  pixel clock; all state on posedge
- rst  in  1  reset, synchronous, active-high
- fsync  in  1  one-cycle frame-start pulse
- hpos, vpos  in  s12  current raster position
- fire_btn  in  1  raw asynchronous fire button
- ship_x  in  s12  ship left edge
- ship_top  in  s12  ship top edge
- alien_hit  in  1  hit pulse from the alien group, level or pulse
- bullet_active  out  1  bullet in flight
- bullet_left, bullet_right, bullet_top, bullet_bottom  out  s12  bounding box; right and bottom are exclusive
- pixel[0:2]  out  3×8  {B,G,R} bullet colour, zero outside the bullet
- active  out  1  current raster position inside the bullet
- shots_fired  out  8  launches, wraps at 255→0
- hits_scored  out  8  alien hits, saturates at 255

## Operation
- **Input conditioning:** fire_btn → two-flop synchronizer → rising-edge detect → `fire_pending` flag.
- `fire_pending` is set only while the state is IDLE. Presses seen in FLIGHT or COOLDOWN are dropped, never queued.
- **State machine:** IDLE, FLIGHT, COOLDOWN.
- **IDLE, on fsync with fire_pending:**
  - Load `left = ship_x + SHIP_W/2 − BULLET_W/2`.
  - Load `top = ship_top − BULLET_H`, clamped to 0 if negative.
  - Clear fire_pending, increment shots_fired, go to FLIGHT.
- **FLIGHT, alien_hit=1 (any cycle):**
  - Go to COOLDOWN and load cooldown_cnt = COOLDOWN_FRAMES.
  - Increment hits_scored (saturating).
  - Hit has priority over fsync in the same cycle; no move happens that cycle.
- **FLIGHT, fsync with no hit:**
  - If `top − BULLET_SPEED < 0`: retire to COOLDOWN (load counter, no hit count).
  - Otherwise `top −= BULLET_SPEED`.
- **COOLDOWN:** decrement cooldown_cnt on each fsync; go to IDLE on the fsync where it reaches 0.
- **Outputs:**
  - bullet_active = (state == FLIGHT).
  - bullet_right = left + BULLET_W; bullet_bottom = top + BULLET_H.
  - Box coordinates hold their last values after retire.
- **Arithmetic:** all position arithmetic is signed 12-bit. The retire compare is done in 13 bits so there is no wrap.
- **Render:** active = bullet_active && left ≤ hpos < right && top ≤ vpos < bottom. pixel = {00,FF,FF} when active, else 0.

## Timing
- **Reset values:** state IDLE; all outputs 0; fire_pending, sync flops and counters 0. Reset mid-flight drops the bullet on the next edge.
- **Button to launch:** fire_btn to fire_pending takes 3 cycles. Launch happens on the first fsync after that. bullet_active and the new coordinates are visible the cycle after that fsync edge.
- **Hit retire:** alien_hit sampled at edge N gives bullet_active=0 after edge N. A hit held high for several cycles counts once, because the state is no longer FLIGHT after the first.
- **Position update:** position registers update on the fsync edge, once per frame.
- **Render path:** pixel and active are combinational from registered state and hpos/vpos, with zero added latency.
- **Cooldown length:** the bullet re-launches no earlier than COOLDOWN_FRAMES fsyncs after retire plus one frame.

## Test plan
- **Launch:** ship_x=300, ship_top=440, press fire, then fsync.
  - Expect active=1, left=315, right=317, top=432, bottom=440, shots_fired=1.
  - Next fsync: top=426.
- **Top-edge retire:** from top=432, after 72 further fsyncs top=0.
  - The 73rd fsync sets bullet_active=0, hits_scored unchanged.
  - After 4 more fsyncs the state is IDLE, and a new press launches again.
- **Hit priority:** pulse alien_hit in the same cycle as fsync while top=426.
  - Expect bullet_active=0 next cycle, top stays 426, hits_scored=1.
  - Hold alien_hit 5 cycles: still hits_scored=1.
- **Dropped presses:** press fire during FLIGHT and during COOLDOWN.
  - shots_fired unchanged; no launch on the first IDLE fsync without a new press.
- **Reset mid-flight:** assert rst while active=1.
  - All outputs 0 next cycle; fire_pending clear; no launch on the following fsync.
- **Render:** bullet at left=315, top=432.
  - (hpos,vpos)=(315,432) gives active=1, pixel={00,FF,FF}.
  - (317,432) and (315,440) give active=0, pixel=0.
